icache_tag_ctrl_nway: RTL

Parametrised N-way instruction-cache tag controller. It generalises the 2-way tag controller to WAYS ways with per-set tree pseudo-LRU. It adds three things: a reset-time tag-RAM clear sweep, snoop invalidation, and per-way MSHR index/way conflict detection. It sits between the fetch/prefetch/snoop request arbiter and the MSHR and data-RAM read path.

---
 rtl/icache_tag_ctrl_nway_pkg.sv | 22 ++
 rtl/icache_plru_tree.sv | 33 +++
 rtl/toy_mem_model_bit.sv | 23 ++
 rtl/icache_tag_ctrl_nway.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_tag_ctrl_nway_pkg.sv
// Shared types for the N-way instruction-cache tag controller.
// Holds the request op encoding, the controller FSM states and small helpers.
package icache_tag_ctrl_nway_pkg;

  typedef enum logic [1:0] {
    OP_FETCH     = 2'd0,
    OP_PREFETCH  = 2'd1,
    OP_SNOOP_INV = 2'd2,
    OP_PROBE     = 2'd3
  } ict_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ict_state_e;

  // FETCH and PREFETCH are the only ops that allocate on miss and age the PLRU.
  function automatic logic is_fill_op(input ict_op_e op);
    return (op == OP_FETCH) || (op == OP_PREFETCH);
  endfunction

endpackage

// File: rtl/icache_plru_tree.sv
// Combinational tree pseudo-LRU for one set: victim select and next bits after a touch.
// Heap order: bit n-1 belongs to node n; a 0 bit steers the victim to the left subtree.
module icache_plru_tree #(
  parameter  int unsigned WAYS = 4,
  localparam int unsigned WW   = $clog2(WAYS)
) (
  input  logic [WAYS-2:0] bits,
  input  logic [WW-1:0]   touch_way,
  output logic [WW-1:0]   victim,
  output logic [WAYS-2:0] bits_nxt
);

  always_comb begin
    int unsigned node;
    node = 1;
    for (int l = 0; l < WW; l++) node = 2 * node + (bits[node-1] ? 1 : 0);
    victim = WW'(node - WAYS);
  end

  // Each node on the touched path is pointed away from the touched way.
  always_comb begin
    int unsigned node;
    logic dir;
    bits_nxt = bits;
    node     = 1;
    for (int l = 0; l < WW; l++) begin
      dir              = touch_way[WW-1-l];
      bits_nxt[node-1] = ~dir;
      node             = 2 * node + (dir ? 1 : 0);
    end
  end

endmodule

// File: rtl/toy_mem_model_bit.sv
// Single-port synchronous RAM model: one read or write per cycle, registered read data.
module toy_mem_model_bit #(
  parameter int unsigned DATA_W = 84,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/icache_tag_ctrl_nway.sv
// N-way I-cache tag controller: init sweep, 2-stage lookup with write-buffer bypass,
// tree PLRU, snoop invalidate and MSHR index/way conflict detection.
module icache_tag_ctrl_nway
  import icache_tag_ctrl_nway_pkg::*;
#(
  parameter  int unsigned WAYS       = 4,
  parameter  int unsigned INDEX_W    = 6,
  parameter  int unsigned TAG_W      = 20,
  parameter  int unsigned MSHR_NUM   = 8,
  parameter  int unsigned MSHR_IDX_W = 3,
  parameter  int unsigned TXN_W      = 5,
  localparam int unsigned WW         = $clog2(WAYS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [TAG_W-1:0]         req_tag,
  input  logic [INDEX_W-1:0]       req_index,
  input  logic [1:0]               req_op,
  input  logic [TXN_W-1:0]         req_txnid,
  input  logic [MSHR_IDX_W-1:0]    req_mshr_idx,
  input  logic [MSHR_IDX_W-1:0]    release_idx,
  input  logic [MSHR_NUM-1:0]      mshr_vld,
  input  logic [MSHR_NUM*INDEX_W-1:0] mshr_index,
  input  logic [MSHR_NUM*WW-1:0]   mshr_way,
  input  logic                     data_rdy,
  output logic                     rsp_vld,
  output logic                     rsp_hit,
  output logic [WW-1:0]            rsp_way,
  output logic [1:0]               rsp_op,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [INDEX_W-1:0]       rsp_index,
  output logic [TXN_W-1:0]         rsp_txnid,
  output logic                     mshr_upd_en,
  output logic [MSHR_NUM-1:0]      conflict_map,
  output logic                     data_rd_vld,
  output logic                     init_busy
);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
  } tag_ent_t;
  typedef tag_ent_t [WAYS-1:0] tag_word_t;

  localparam int unsigned SETS    = 1 << INDEX_W;
  localparam int unsigned WORD_W  = WAYS * (TAG_W + 1);
  localparam logic [INDEX_W-1:0] TOP_SET = '1;

  ict_state_e          state_q, state_d;
  logic [INDEX_W-1:0]  init_cnt_q, init_cnt_d;
  logic                init_busy_q;

  logic                s1_vld_q, s1_vld_d;
  ict_op_e             s1_op_q, s1_op_d;
  logic [TAG_W-1:0]    s1_tag_q, s1_tag_d;
  logic [INDEX_W-1:0]  s1_idx_q, s1_idx_d;
  logic [TXN_W-1:0]    s1_txn_q, s1_txn_d;
  logic [MSHR_IDX_W-1:0] s1_midx_q, s1_midx_d;

  logic                wbuf_vld_q, wbuf_vld_d;
  logic [INDEX_W-1:0]  wbuf_idx_q, wbuf_idx_d;
  tag_word_t           wbuf_word_q, wbuf_word_d;

  logic [WAYS-2:0]     plru_q [SETS];
  logic [WAYS-2:0]     plru_row, plru_row_d;
  logic [WW-1:0]       plru_vic;
  logic                plru_we;

  logic                acc;
  logic                ram_en, ram_we;
  logic [INDEX_W-1:0]  ram_addr;
  tag_word_t           ram_wdata, ram_rdata, s1_word;

  logic                hit_any, inv_any, fill_op;
  logic [WW-1:0]       hit_way, inv_way, victim_way, rsp_way_c;

  // ---- init sweep FSM ----
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      if (init_cnt_q == TOP_SET) state_d = ST_RUN;
      else                       init_cnt_d = init_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_busy_q <= (state_d == ST_INIT);
    end
  end

  assign req_rdy = (state_q == ST_RUN) & ~wbuf_vld_q & ~stall;
  assign acc     = req_vld & req_rdy;

  // ---- tag RAM port: sweep write, else wbuf write, else lookup read ----
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = req_index;
    ram_wdata = '0;
    if (state_q == ST_INIT) begin
      ram_en   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = init_cnt_q;
    end else if (wbuf_vld_q) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wbuf_idx_q;
      ram_wdata = wbuf_word_q;
    end else if (acc) begin
      ram_en = 1'b1;
    end
  end

  toy_mem_model_bit #(.DATA_W(WORD_W), .ADDR_W(INDEX_W)) u_tag_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---- stage 1 registers ----
  always_comb begin
    s1_vld_d  = acc;
    s1_op_d   = s1_op_q;
    s1_tag_d  = s1_tag_q;
    s1_idx_d  = s1_idx_q;
    s1_txn_d  = s1_txn_q;
    s1_midx_d = s1_midx_q;
    if (acc) begin
      s1_op_d   = ict_op_e'(req_op);
      s1_tag_d  = req_tag;
      s1_idx_d  = req_index;
      s1_txn_d  = req_txnid;
      s1_midx_d = req_mshr_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q  <= 1'b0;
      s1_op_q   <= OP_FETCH;
      s1_tag_q  <= '0;
      s1_idx_q  <= '0;
      s1_txn_q  <= '0;
      s1_midx_q <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_op_q   <= s1_op_d;
      s1_tag_q  <= s1_tag_d;
      s1_idx_q  <= s1_idx_d;
      s1_txn_q  <= s1_txn_d;
      s1_midx_q <= s1_midx_d;
    end
  end

  // The RAM read was issued before the pending wbuf write landed; take the newer word.
  assign s1_word = (wbuf_vld_q && (wbuf_idx_q == s1_idx_q)) ? wbuf_word_q : ram_rdata;

  // Descending scan so the lowest matching / invalid way is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (s1_word[w].vld && (s1_word[w].tag == s1_tag_q)) begin
        hit_any = 1'b1;
        hit_way = WW'(w);
      end
      if (!s1_word[w].vld) begin
        inv_any = 1'b1;
        inv_way = WW'(w);
      end
    end
  end

  assign plru_row   = plru_q[s1_idx_q];
  assign victim_way = inv_any ? inv_way : plru_vic;
  assign rsp_way_c  = hit_any ? hit_way : victim_way;
  assign fill_op    = is_fill_op(s1_op_q);
  assign plru_we    = s1_vld_q & fill_op;

  icache_plru_tree #(.WAYS(WAYS)) u_plru (
    .bits      (plru_row),
    .touch_way (rsp_way_c),
    .victim    (plru_vic),
    .bits_nxt  (plru_row_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[s1_idx_q] <= plru_row_d;
    end
  end

  // ---- write buffer: miss fill or snoop invalidate, written to RAM next cycle ----
  always_comb begin
    wbuf_vld_d  = 1'b0;
    wbuf_idx_d  = wbuf_idx_q;
    wbuf_word_d = wbuf_word_q;
    if (s1_vld_q) begin
      if (!hit_any && fill_op) begin
        wbuf_vld_d              = 1'b1;
        wbuf_idx_d              = s1_idx_q;
        wbuf_word_d             = s1_word;
        wbuf_word_d[victim_way] = '{vld: 1'b1, tag: s1_tag_q};
      end else if (hit_any && (s1_op_q == OP_SNOOP_INV)) begin
        wbuf_vld_d               = 1'b1;
        wbuf_idx_d               = s1_idx_q;
        wbuf_word_d              = s1_word;
        wbuf_word_d[hit_way].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_vld_q  <= 1'b0;
      wbuf_idx_q  <= '0;
      wbuf_word_q <= '0;
    end else begin
      wbuf_vld_q  <= wbuf_vld_d;
      wbuf_idx_q  <= wbuf_idx_d;
      wbuf_word_q <= wbuf_word_d;
    end
  end

  // ---- outputs ----
  assign rsp_vld     = s1_vld_q;
  assign rsp_hit     = s1_vld_q & hit_any;
  assign rsp_way     = rsp_way_c;
  assign rsp_op      = s1_op_q;
  assign rsp_tag     = s1_tag_q;
  assign rsp_index   = s1_idx_q;
  assign rsp_txnid   = s1_txn_q;
  assign init_busy   = init_busy_q;
  assign mshr_upd_en = s1_vld_q & (s1_op_q != OP_SNOOP_INV);

  // The entry being allocated now and the one retiring now never count as conflicts.
  always_comb begin
    conflict_map = '0;
    for (int i = 0; i < MSHR_NUM; i++) begin
      conflict_map[i] = mshr_upd_en & mshr_vld[i]
                      & (mshr_index[i*INDEX_W +: INDEX_W] == s1_idx_q)
                      & (mshr_way[i*WW +: WW] == rsp_way_c)
                      & (MSHR_IDX_W'(i) != s1_midx_q)
                      & (MSHR_IDX_W'(i) != release_idx);
    end
  end

  assign data_rd_vld = rsp_vld & rsp_hit & fill_op & ~(|conflict_map) & data_rdy;

endmodule
